// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard inputs and register-control outputs between datapath and pipeline_ctrl
interface pipeline_ctrl_if;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic       ex_valid;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       ex_branch_taken;
    logic       imem_ready;
    logic       mem_access;
    logic       mem_ready;
    logic       if_en;
    logic       id_en;
    logic       ex_en;
    logic       mem_en;
    logic       if_kill;
    logic       id_bubble;
    logic       pc_redirect;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_valid, ex_rd, ex_mem_read, ex_branch_taken,
        output imem_ready, mem_access, mem_ready,
        input  if_en, id_en, ex_en, mem_en, if_kill, id_bubble, pc_redirect
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_valid, ex_rd, ex_mem_read, ex_branch_taken,
        input  imem_ready, mem_access, mem_ready,
        output if_en, id_en, ex_en, mem_en, if_kill, id_bubble, pc_redirect
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - five-stage pipeline hazard/sequencing controller with memory watchdog and perf counters
module pipeline_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    pipeline_ctrl_if.slave   pipe,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);
    localparam int WD_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(MEM_TIMEOUT);
    localparam bit WD_ON = (MEM_TIMEOUT != 0);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    state_t           state_q, state_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic mem_stall, freeze, redirect, load_use, wd_fire;
    logic if_en, id_en, ex_en, mem_en, if_kill, id_bubble, pc_redirect;

    assign mem_stall = pipe.mem_access & ~pipe.mem_ready;
    assign freeze    = (state_q == ERR) | mem_stall;
    assign redirect  = pipe.ex_valid & pipe.ex_branch_taken;
    assign load_use  = pipe.ex_valid & pipe.ex_mem_read & (pipe.ex_rd != 5'd0) & pipe.id_valid &
                       ((pipe.id_uses_rs1 & (pipe.id_rs1 == pipe.ex_rd)) |
                        (pipe.id_uses_rs2 & (pipe.id_rs2 == pipe.ex_rd)));
    assign wd_fire   = WD_ON & mem_stall & (wd_q == WD_MAX - 1'b1);

    // Controls are held quiet during reset so no register loads garbage.
    always_comb begin
        if_en       = 1'b0;
        id_en       = 1'b0;
        ex_en       = 1'b0;
        mem_en      = 1'b0;
        if_kill     = 1'b0;
        id_bubble   = 1'b0;
        pc_redirect = 1'b0;
        if (!rst_n || freeze) begin
            if_en = 1'b0;
        end else if (redirect) begin
            {if_en, id_en, ex_en, mem_en} = 4'b1111;
            if_kill     = 1'b1;
            id_bubble   = 1'b1;
            pc_redirect = 1'b1;
        end else if (load_use) begin
            {ex_en, mem_en} = 2'b11;
            id_bubble       = 1'b1;
        end else if (!pipe.imem_ready) begin
            {id_en, ex_en, mem_en} = 3'b111;
            if_kill                = 1'b1;
        end else begin
            {if_en, id_en, ex_en, mem_en} = 4'b1111;
        end
    end

    assign pipe.if_en       = if_en;
    assign pipe.id_en       = id_en;
    assign pipe.ex_en       = ex_en;
    assign pipe.mem_en      = mem_en;
    assign pipe.if_kill     = if_kill;
    assign pipe.id_bubble   = id_bubble;
    assign pipe.pc_redirect = pc_redirect;

    always_comb begin
        state_d   = state_q;
        mem_err_d = mem_err_q;
        wd_d      = '0;
        if (WD_ON && mem_stall)
            wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
        case (state_q)
            RUN:      if (mem_stall) state_d = MEM_WAIT;
            MEM_WAIT: if (pipe.mem_ready || !pipe.mem_access) state_d = RUN;
            ERR:      state_d = ERR;
            default:  state_d = RUN;
        endcase
        if (wd_fire && state_q != ERR) begin
            state_d   = ERR;
            mem_err_d = 1'b1;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (!if_en && stall_cycles_q != '1)
            stall_cycles_d = stall_cycles_q + 1'b1;
        if (pc_redirect && flush_count_q != '1)
            flush_count_d = flush_count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            wd_q           <= '0;
            mem_err_q      <= 1'b0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            wd_q           <= wd_d;
            mem_err_q      <= mem_err_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl (MEM_TIMEOUT=4, CNT_W=4)
module tb_pipeline_ctrl;
    localparam int CNT_W = 4;

    // {if_en,id_en,ex_en,mem_en,if_kill,id_bubble,pc_redirect}
    localparam logic [6:0] C_ALL    = 7'b1111_000;
    localparam logic [6:0] C_FREEZE = 7'b0000_000;
    localparam logic [6:0] C_REDIR  = 7'b1111_111;
    localparam logic [6:0] C_LU     = 7'b0011_010;
    localparam logic [6:0] C_FMISS  = 7'b0111_100;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;
    logic [6:0]       ctl_obs;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] exp_q[$];
    string      tag_q[$];

    pipeline_ctrl_if bus ();

    pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pipe         (bus),
        .mem_err      (mem_err),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    assign ctl_obs = {bus.if_en, bus.id_en, bus.ex_en, bus.mem_en,
                      bus.if_kill, bus.id_bubble, bus.pc_redirect};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        bus.id_valid        = 1'b1;
        bus.id_rs1          = 5'd1;
        bus.id_rs2          = 5'd2;
        bus.id_uses_rs1     = 1'b0;
        bus.id_uses_rs2     = 1'b0;
        bus.ex_valid        = 1'b1;
        bus.ex_rd           = 5'd3;
        bus.ex_mem_read     = 1'b0;
        bus.ex_branch_taken = 1'b0;
        bus.imem_ready      = 1'b1;
        bus.mem_access      = 1'b0;
        bus.mem_ready       = 1'b1;
    endtask

    // Inputs are already driven; expected controls go in, get compared mid-cycle.
    task automatic step(input string tag, input logic [6:0] exp);
        logic [6:0] e;
        string      t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check({tag, "_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, {25'd0, ctl_obs}, {25'd0, e});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_ctl"},   {25'd0, ctl_obs}, 32'd0);
        check({tag, "_rst_stall"}, {28'd0, stall_cycles}, 32'd0);
        check({tag, "_rst_flush"}, {28'd0, flush_count}, 32'd0);
        check({tag, "_rst_err"},   {31'd0, mem_err}, 32'd0);
        set_idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", n_checks);
        $fatal(1, "bench did not finish");
    end

    initial begin
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        do_reset("init");
        step("idle", C_ALL);

        // Load-use on rs1, one cycle only
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5;
        bus.id_uses_rs1 = 1'b1; bus.id_rs1 = 5'd5; bus.id_rs2 = 5'd1;
        step("lu_rs1", C_LU);
        set_idle();
        step("lu_next", C_ALL);
        check("lu_stall", {28'd0, stall_cycles}, 32'd1);
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd7;
        bus.id_uses_rs2 = 1'b1; bus.id_rs2 = 5'd7;
        step("lu_rs2", C_LU);
        bus.id_uses_rs2 = 1'b0;
        step("lu_unused", C_ALL);
        bus.id_uses_rs2 = 1'b1; bus.id_valid = 1'b0;
        step("lu_id_inv", C_ALL);
        set_idle();
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd0;
        bus.id_uses_rs1 = 1'b1; bus.id_rs1 = 5'd0;
        step("x0_guard", C_ALL);
        check("lu_stall2", {28'd0, stall_cycles}, 32'd2);

        // Branch beats load-use and fetch miss; held branch redirects once after freeze
        do_reset("br");
        bus.ex_branch_taken = 1'b1; bus.imem_ready = 1'b0;
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5;
        bus.id_uses_rs1 = 1'b1; bus.id_rs1 = 5'd5;
        step("br_hazard", C_REDIR);
        set_idle();
        bus.ex_branch_taken = 1'b1; bus.ex_valid = 1'b0;
        step("br_ex_inv", C_ALL);
        check("br_flush1", {28'd0, flush_count}, 32'd1);
        set_idle();
        bus.ex_branch_taken = 1'b1; bus.mem_access = 1'b1; bus.mem_ready = 1'b0;
        step("br_frozen", C_FREEZE);
        bus.mem_ready = 1'b1;
        step("br_release", C_REDIR);
        set_idle();
        step("br_after", C_ALL);
        check("br_flush2", {28'd0, flush_count}, 32'd2);
        check("br_stall", {28'd0, stall_cycles}, 32'd1);

        // Memory wait of three cycles, completion cycle runs normally
        do_reset("mw");
        bus.mem_access = 1'b1; bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step($sformatf("mw_frz%0d", i), C_FREEZE);
        bus.mem_ready = 1'b1; bus.imem_ready = 1'b0;
        step("mw_done_fmiss", C_FMISS);
        set_idle();
        step("mw_idle", C_ALL);
        check("mw_stall", {28'd0, stall_cycles}, 32'd4);
        check("mw_err", {31'd0, mem_err}, 32'd0);

        // Watchdog fires on the fourth wait edge; ERR freezes until reset
        do_reset("wd");
        bus.mem_access = 1'b1; bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step($sformatf("wd_frz%0d", i), C_FREEZE);
        check("wd_err_pre", {31'd0, mem_err}, 32'd0);
        step("wd_frz3", C_FREEZE);
        check("wd_err_set", {31'd0, mem_err}, 32'd1);
        bus.mem_ready = 1'b1;
        step("wd_err_rdy", C_FREEZE);
        set_idle();
        step("wd_err_idle", C_FREEZE);
        check("wd_err_hold", {31'd0, mem_err}, 32'd1);
        check("wd_stall", {28'd0, stall_cycles}, 32'd6);
        do_reset("wd_clr");
        step("wd_run_again", C_ALL);

        // Fetch miss saturates the stall counter
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 20; i++) step($sformatf("fm%0d", i), C_FMISS);
        check("sat_stall", {28'd0, stall_cycles}, 32'd15);
        check("sat_flush", {28'd0, flush_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the five-stage RV32IC integer pipeline. Each cycle it drives the load enables and kill controls for the IF/ID/EX/MEM pipeline registers. It freezes the pipe on data-memory wait states, inserts a bubble on load-use hazards, flushes on taken branches and jumps, and bubbles decode on instruction-fetch misses. It also keeps a data-memory timeout watchdog and two saturating performance counters.

## Interface
Parameters:
- MEM_TIMEOUT, 64: consecutive data-memory wait cycles before a fatal error; 0 disables the watchdog
- CNT_W, 32: width of the performance counters

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  the ID register holds a live instruction
- id_rs1, id_rs2  in  5  source register numbers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  the instruction in ID reads rs1 / rs2
- ex_valid  in  1  the EX register holds a live instruction
- ex_rd  in  5  destination register of the instruction in EX
- ex_mem_read  in  1  the instruction in EX is a load
- ex_branch_taken  in  1  EX resolved a taken branch or jump this cycle
- imem_ready  in  1  fetch data is valid this cycle
- mem_access  in  1  the MEM stage holds a load or store
- mem_ready  in  1  data memory completes the MEM-stage access this cycle
- if_en, id_en, ex_en, mem_en  out  1  load enables for PC/IF, ID, EX and MEM registers
- if_kill  out  1  load an invalid (NOP) instruction into ID
- id_bubble  out  1  load a zeroed EX_STATE (no RegWrite/MemRead/MemWrite/branch) into EX
- pc_redirect  out  1  select the EX branch target as the next PC
- mem_err  out  1  sticky watchdog error
- stall_cycles  out  CNT_W  cycles with if_en=0
- flush_count  out  CNT_W  cycles with pc_redirect=1

## Operation
- FSM states: RUN, MEM_WAIT, ERR. Reset state is RUN.
- Control outputs are combinational from the state and inputs. They are evaluated with the following priority, highest first.
- Priority 1, freeze:
  - Condition: state ERR, or mem_access & !mem_ready.
  - Outputs: all enables 0, if_kill=0, id_bubble=0, pc_redirect=0.
- Priority 2, redirect:
  - Condition: ex_valid & ex_branch_taken.
  - Outputs: pc_redirect=1, if_kill=1, id_bubble=1, all enables 1.
  - The load-use and fetch conditions are ignored because the younger instructions are discarded.
- Priority 3, load-use:
  - Condition: ex_valid & ex_mem_read & ex_rd!=0 & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - Outputs: if_en=0, id_en=0, id_bubble=1, ex_en=1, mem_en=1.
- Priority 4, fetch miss:
  - Condition: !imem_ready.
  - Outputs: if_en=0, if_kill=1, other enables 1.
- Otherwise: all enables 1, all kills 0, pc_redirect=0.
- FSM transitions:
  - RUN→MEM_WAIT on mem_access & !mem_ready.
  - MEM_WAIT→RUN on mem_ready, or when mem_access drops.
  - RUN or MEM_WAIT→ERR when the watchdog fires.
  - ERR is left only by reset.
- Watchdog counter:
  - It increments on every cycle with mem_access & !mem_ready and clears on any other cycle.
  - When MEM_TIMEOUT≠0 and the counter would reach MEM_TIMEOUT, the next state is ERR and mem_err is set.
  - Counter width is clog2(MEM_TIMEOUT+1), minimum 1.
- Performance counters:
  - stall_cycles increments when if_en=0; flush_count increments when pc_redirect=1.
  - Both saturate at all-ones and hold that value.
  - Neither counts while rst_n is low.

## Timing
- Reset (asynchronous): state=RUN, watchdog=0, mem_err=0, stall_cycles=0, flush_count=0.
- While rst_n=0: all enables=0, if_kill=0, id_bubble=0, pc_redirect=0.
- Zero-cycle latency: controls respond in the same cycle as their inputs. The FSM state and counters update at the next edge.
- The memory-completion cycle (MEM_WAIT with mem_ready=1) is not a freeze. Priorities 2-4 apply in that same cycle.
- A branch held in EX during a freeze redirects only in the first unfrozen cycle, and flush_count counts it exactly once.
- A load-use hazard lasts exactly one cycle: the next cycle the load has moved to MEM and the condition clears.
- ex_rd=0 never creates a hazard.
- Reset asserted mid-MEM_WAIT or in ERR returns to RUN asynchronously.

## Test plan
- Load-use: EX lw x5 (ex_mem_read=1, ex_rd=5); ID add x6,x5,x1 (id_uses_rs1=1, id_rs1=5) → exactly one cycle with if_en=0, id_en=0, id_bubble=1; next cycle all enables 1; stall_cycles=1.
- x0 guard: same as the load-use case but ex_rd=0, id_rs1=0 → no stall; all enables 1.
- Branch over hazard: ex_branch_taken=1 together with a load-use match and imem_ready=0 → pc_redirect=1, if_kill=1, id_bubble=1, all enables 1; flush_count=1.
- Memory wait: mem_access=1, mem_ready=0 for 3 cycles, then 1 → 3 frozen cycles (state MEM_WAIT after the 1st edge); normal enables on the 4th cycle; stall_cycles=3; mem_err=0.
- Watchdog: MEM_TIMEOUT=4, mem_ready held 0 → mem_err=1 after the 4th stall edge; pipe stays frozen after mem_ready rises; rst_n pulse clears mem_err and all counters to 0.
- Saturation: CNT_W=4, hold imem_ready=0 for 20 cycles → stall_cycles stops at 15.
